// File: rtl/activity_pkg.sv
// Shared constants and types for the step-rate meter and the activity trackers
// that consume its ppm output.
package activity_pkg;

  localparam int PPM_W       = 10;
  localparam int WIN_SECS    = 60;
  localparam int HI_THRESH   = 64;
  localparam int BKT_W       = 8;
  localparam int LOCKOUT_CYC = 4;

  typedef logic [PPM_W-1:0] ppm_t;

  // Width of a sum of win full buckets, so the running window sum cannot overflow.
  function automatic int sum_width(input int win, input int bkt_w);
    return $clog2(win * ((1 << bkt_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/step_rate_meter_if.sv
// Step-pulse / ppm bundle between the step source, the meter and the trackers.
interface step_rate_meter_if #(
  parameter int BKT_W = 8,
  parameter int PPM_W = 10
);

  logic             sec_tick;
  logic             step;
  logic [PPM_W-1:0] ppm;
  logic             ppm_valid;
  logic             hi_act;
  logic [BKT_W-1:0] sec_cnt;

  modport master (
    output sec_tick, step,
    input  ppm, ppm_valid, hi_act, sec_cnt
  );

  modport slave (
    input  sec_tick, step,
    output ppm, ppm_valid, hi_act, sec_cnt
  );

endinterface

// File: rtl/step_rate_ring.sv
// WIN_SECS-deep ring of closed per-second buckets with a running window sum.
module step_rate_ring #(
  parameter int WIN_SECS = 60,
  parameter int BKT_W    = 8,
  parameter int SUM_W    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [BKT_W-1:0] closing,
  output logic [SUM_W-1:0] sum
);

  localparam int PTR_W = $clog2(WIN_SECS);

  logic [BKT_W-1:0] bkt [WIN_SECS];
  logic [PTR_W-1:0] wr_ptr;

  // The slot being overwritten is the bucket leaving the window, so the sum is
  // adjusted incrementally instead of re-adding all WIN_SECS buckets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIN_SECS; i++) bkt[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (wr_en) begin
      bkt[wr_ptr] <= closing;
      sum         <= sum + SUM_W'(closing) - SUM_W'(bkt[wr_ptr]);
      wr_ptr      <= (wr_ptr == PTR_W'(WIN_SECS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/step_rate_meter.sv
// Step-pulse rate meter: 1 s buckets, WIN_SECS sliding window, registered ppm.
// Optional build macro STEP_LOCKOUT_EN ignores steps for LOCKOUT_CYC cycles after an accepted one.
module step_rate_meter
  import activity_pkg::*;
#(
  parameter int WIN_SECS    = activity_pkg::WIN_SECS,
  parameter int BKT_W       = activity_pkg::BKT_W,
  parameter int PPM_W       = activity_pkg::PPM_W,
  parameter int HI_THRESH   = activity_pkg::HI_THRESH,
  parameter int LOCKOUT_CYC = activity_pkg::LOCKOUT_CYC
) (
  input  logic               clk,
  input  logic               reset,
  step_rate_meter_if.slave   bus
);

  localparam int SUM_W   = sum_width(WIN_SECS, BKT_W);
  localparam int FILL_W  = $clog2(WIN_SECS + 1);
  localparam int PPM_MAX = (1 << PPM_W) - 1;

  localparam logic [BKT_W-1:0] BKT_MAX = '1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic             step_ok;
  logic [BKT_W-1:0] sec_cnt;
  logic [BKT_W-1:0] closing;
  logic [SUM_W-1:0] sum;
  logic [FILL_W-1:0] fill;
  logic [0:0]       state;
  logic [PPM_W-1:0] ppm;

`ifdef STEP_LOCKOUT_EN
  localparam int LCK_W = $clog2(LOCKOUT_CYC + 1);

  logic [LCK_W-1:0] lock_cnt;

  assign step_ok = bus.step && (lock_cnt == '0);

  // Lockout spans second boundaries; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (step_ok) begin
      lock_cnt <= LCK_W'(LOCKOUT_CYC);
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end
`else
  localparam int lockout_unused = LOCKOUT_CYC;

  assign step_ok = bus.step;
`endif

  // A step on the tick edge belongs to the second being closed.
  assign closing = (sec_cnt == BKT_MAX) ? BKT_MAX : sec_cnt + BKT_W'(step_ok);

  step_rate_ring #(
    .WIN_SECS (WIN_SECS),
    .BKT_W    (BKT_W),
    .SUM_W    (SUM_W)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.sec_tick),
    .closing (closing),
    .sum     (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_cnt <= '0;
      fill    <= '0;
      state   <= FILL;
      ppm     <= '0;
    end else begin
      if (bus.sec_tick) begin
        sec_cnt <= '0;
      end else if (step_ok && sec_cnt != BKT_MAX) begin
        sec_cnt <= sec_cnt + 1'b1;
      end

      if (bus.sec_tick && fill != FILL_W'(WIN_SECS)) begin
        fill <= fill + 1'b1;
      end

      // fill reaches WIN_SECS on the last tick edge; state follows one cycle
      // later so ppm_valid rises together with the full-window ppm.
      if (state == FILL && fill == FILL_W'(WIN_SECS)) begin
        state <= RUN;
      end

      ppm <= (sum > SUM_W'(PPM_MAX)) ? '1 : PPM_W'(sum);
    end
  end

  assign bus.ppm       = ppm;
  assign bus.ppm_valid = (state == RUN);
  assign bus.hi_act    = (ppm >= PPM_W'(HI_THRESH));
  assign bus.sec_cnt   = sec_cnt;

endmodule

// File: tb/tb_step_rate_meter.sv
// Randomized and directed checks of step_rate_meter against a window-of-seconds queue model.
module tb_step_rate_meter;

  localparam int W    = 60;
  localparam int BK   = 8;
  localparam int PW   = 10;
  localparam int HT   = 64;
  localparam int LC   = 4;
  localparam int BMAX = (1 << BK) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  step_rate_meter_if #(.BKT_W(BK), .PPM_W(PW)) bus ();

  step_rate_meter #(
    .WIN_SECS    (W),
    .BKT_W       (BK),
    .PPM_W       (PW),
    .HI_THRESH   (HT),
    .LOCKOUT_CYC (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference: list of closed seconds (newest last), current open count,
  // number of ticks since reset, cycle of last accepted step.
  int unsigned closed[$];
  int unsigned cur;
  int unsigned ticks;
  longint      cyc;
  longint      last_acc;
  bit          have_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned window_sum();
    int unsigned s = 0;
    foreach (closed[i]) s += closed[i];
    return s;
  endfunction

  task automatic model_reset();
    closed.delete();
    cur      = 0;
    ticks    = 0;
    have_acc = 1'b0;
  endtask

  task automatic cycle(input bit s, input bit t, input bit r);
    int unsigned exp_ppm;
    bit          exp_valid;
    bit          acc;
    int unsigned cl;
    bus.step     = s;
    bus.sec_tick = t;
    reset        = r;
    @(posedge clk);
    exp_ppm   = r ? 0 : ((window_sum() > PMAX) ? PMAX : window_sum());
    exp_valid = !r && (ticks >= W);
    if (r) begin
      model_reset();
    end else begin
      acc = s;
`ifdef STEP_LOCKOUT_EN
      acc = s && (!have_acc || (cyc - last_acc) > LC);
`endif
      if (acc) begin
        have_acc = 1'b1;
        last_acc = cyc;
      end
      if (t) begin
        cl = cur + (acc ? 1 : 0);
        if (cl > BMAX) cl = BMAX;
        closed.push_back(cl);
        if (closed.size() > W) void'(closed.pop_front());
        ticks++;
        cur = 0;
      end else if (acc && cur < BMAX) begin
        cur++;
      end
    end
    cyc++;
    #1;
    check("ppm",       32'(bus.ppm),       exp_ppm);
    check("ppm_valid", 32'(bus.ppm_valid), 32'(exp_valid));
    check("hi_act",    32'(bus.hi_act),    32'(exp_ppm >= HT));
    check("sec_cnt",   32'(bus.sec_cnt),   cur);
  endtask

  // n separated steps, idle cycles, then the tick (optionally carrying a step).
  task automatic second(input int n, input bit coinc, input int idle);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < idle; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(coinc, 1'b1, 1'b0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Fill ramp, then drain with back-to-back ticks.
    for (int i = 0; i < W; i++) second(2, 1'b0, 1);
    for (int i = 0; i < W; i++) second(0, 1'b0, 0);

    // Step on the tick edge plus one other step.
    second(1, 1'b1, 1);
    cycle(1'b0, 1'b0, 1'b0);

    // Saturated buckets, then let them age out.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 300; k++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < W; i++) second(0, 1'b0, 0);

    // Reset mid-window together with step and tick, then full refill.
    for (int i = 0; i < 30; i++) second(2, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) second(1, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0);

    // Burst of consecutive step pulses.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
`ifdef STEP_LOCKOUT_EN
    check("burst_count", 32'(bus.sec_cnt), 32'd2);
`else
    check("burst_count", 32'(bus.sec_cnt), 32'd8);
`endif
    cycle(1'b0, 1'b1, 1'b0);

    // Random traffic with occasional resets and heavy bursts.
    for (int i = 0; i < 6000; i++) begin
      bit s, t, r;
      r = ($urandom_range(0, 2499) == 0);
      t = ($urandom_range(0, 7) == 0);
      s = (i % 1500 < 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(s, t, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
